instr_queue: RTL

- FIFO between fetch and decode/issue.
- Captures one predecoded fetch packet per cycle: pc, instruction, prediction, branch, jump (pipe_in_t).
- Presents packets in order to the issue side with a valid/ready handshake.
- Drives the back-pressure (full) that stalls fetch; discards all contents on a mispredict flush.

---
 rtl/instr_queue_if.sv | 33 +++
 rtl/instr_queue.sv | 64 ++++++
 2 files changed

// File: rtl/instr_queue_if.sv
// Fetch-to-issue queue bus: fetch/issue side drives through master, the queue sits on slave.
// Packet layout is {pc[31:0], instruction[31:0], prediction, branch, jump}.
interface instr_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;

    logic           in_valid;
    pipe_in_t       pipe_in;
    logic           flush;
    logic           out_ready;
    logic           full;
    logic           out_valid;
    pipe_in_t       pipe_out;
    logic [PTR_W:0] count;

    modport master (
        output in_valid, pipe_in, flush, out_ready,
        input  full, out_valid, pipe_out, count
    );

    modport slave (
        input  in_valid, pipe_in, flush, out_ready,
        output full, out_valid, pipe_out, count
    );
endinterface

// File: rtl/instr_queue.sv
// In-order packet FIFO between fetch and decode/issue with flush-on-mispredict.
// full/out_valid come from the registered occupancy only, so out_ready never reaches full.
module instr_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            reset,
    instr_queue_if.slave   q
);
    localparam int unsigned    PKT_W    = 67;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop, full_w, valid_w;

    always_comb begin
        full_w   = (count_q == FULL_CNT);
        valid_w  = (count_q != '0);
        push     = q.in_valid & ~full_w & ~q.flush;
        pop      = valid_w & q.out_ready & ~q.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= q.pipe_in;
    end

    assign q.full      = full_w;
    assign q.out_valid = valid_w;
    assign q.count     = count_q;
    assign q.pipe_out  = valid_w ? mem_q[rd_ptr_q] : '0;
endmodule
